// File: rtl/booth_pkg.sv
// Shared types, constants and helpers for the radix-2 Booth multiplier.
// Recode constants name the {Q[0],Q_1} bit pairs that select add/sub/no-op.
package booth_pkg;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    typedef enum logic {
        S_RUN,
        S_DONE
    } booth_state_t;

    localparam logic [1:0] RC_IDLE0 = 2'b00;
    localparam logic [1:0] RC_ADD   = 2'b01;
    localparam logic [1:0] RC_SUB   = 2'b10;
    localparam logic [1:0] RC_IDLE1 = 2'b11;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB
    } booth_op_t;

    function automatic booth_op_t recode(input logic [1:0] bits);
        booth_op_t op;
        op = OP_NOP;
        case (bits)
            RC_IDLE0: op = OP_NOP;
            RC_ADD:   op = OP_ADD;
            RC_SUB:   op = OP_SUB;
            RC_IDLE1: op = OP_NOP;
            default:  op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: recode, add/sub M, then
// arithmetic shift right of {ACC,Q,Q_1}. Zero latency, no flow control.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             q_1_nxt
);

    logic [WIDTH:0] sum;
    booth_op_t      op;

    always_comb begin
        op  = recode({q[0], q_1});
        sum = acc;
        case (op)
            OP_ADD:  sum = acc + m;
            OP_SUB:  sum = acc - m;
            default: sum = acc;
        endcase
    end

    // ASR by one: the accumulator sign bit replicates, its LSB moves into Q.
    assign acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
    assign q_nxt   = {sum[0], q[WIDTH-1:1]};
    assign q_1_nxt = q[0];

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed Booth multiplier; every reset loads A/B and starts a multiply.
// Product valid WIDTH edges after the reset edge, then held; no handshake/backpressure.
module booth_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   AXB,
    output logic [CNT_W-1:0]     n
);

    localparam logic [CNT_W-1:0] N_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] N_ONE  = CNT_W'(1);

    booth_state_t     state;
    booth_state_t     state_nxt;
    logic             step_en;
    logic             axb_load;

    // One extra accumulator bit keeps M = -2^(WIDTH-1) from overflowing.
    logic [WIDTH:0]   m;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             q_1;

    logic [WIDTH:0]   acc_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             q_1_nxt;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc     (acc),
        .q       (q),
        .q_1     (q_1),
        .m       (m),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt),
        .q_1_nxt (q_1_nxt)
    );

    always_comb begin
        state_nxt = state;
        step_en   = 1'b0;
        axb_load  = 1'b0;
        case (state)
            S_RUN: begin
                if (n != '0) begin
                    step_en = 1'b1;
                    if (n == N_ONE) begin
                        axb_load  = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m     <= {A[WIDTH-1], A};
            acc   <= '0;
            q     <= B;
            q_1   <= 1'b0;
            n     <= N_INIT;
            AXB   <= '0;
            state <= S_RUN;
        end else begin
            state <= state_nxt;
            if (step_en) begin
                acc <= acc_nxt;
                q   <= q_nxt;
                q_1 <= q_1_nxt;
                n   <= n - N_ONE;
            end
            // Only the final step's shifted result reaches AXB; partials never do.
            if (axb_load) begin
                AXB <= {acc_nxt[WIDTH-1:0], q_nxt};
            end
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed and exhaustive checks of booth_multiplier with a product scoreboard.
module tb_booth_multiplier;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] AXB;
    logic [2:0] n;

    int         tests;
    int         fails;
    logic [7:0] sb[$];
    logic [7:0] last_p;

    booth_multiplier dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .AXB (AXB),
        .n   (n)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        int         ai;
        int         bi;
        int         p;
        logic [7:0] r;
        ai = $signed(a);
        bi = $signed(b);
        p  = ai * bi;
        r  = p[7:0];
        return r;
    endfunction

    // Called at a negedge (or time 0); returns at the negedge after the reset edge.
    task automatic start(input logic [3:0] a, input logic [3:0] b);
        A   = a;
        B   = b;
        rst = 1'b1;
        sb.push_back(ref_mul(a, b));
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Tracks n from first_n down to 0, AXB zero until the end, then scoreboard pop.
    task automatic follow(input string tag, input int first_n);
        logic [7:0] exp_p;
        for (int k = first_n; k >= 0; k--) begin
            check({tag, "_n"}, 8'(n), 8'(k));
            if (k != 0) begin
                check({tag, "_axb_zero"}, AXB, 8'h00);
                @(negedge clk);
            end else if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
            end else begin
                exp_p  = sb.pop_front();
                last_p = exp_p;
                check({tag, "_axb"}, AXB, exp_p);
            end
        end
    endtask

    task automatic hold(input string tag, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            check({tag, "_hold_axb"}, AXB, last_p);
            check({tag, "_hold_n"}, 8'(n), 8'h00);
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        last_p = '0;
        A      = '0;
        B      = '0;
        rst    = 1'b0;

        // 7 * 3 = 21, with reset-state and hold checks
        start(4'b0111, 4'b0011);
        check("reset_axb", AXB, 8'h00);
        check("reset_n", 8'(n), 8'h04);
        follow("mul_7x3", 4);
        check("mul_7x3_const", last_p, 8'h15);
        hold("mul_7x3", 3);

        // most-negative operands exercise the extra accumulator bit
        start(4'b1000, 4'b1000);
        follow("mul_m8xm8", 4);
        hold("mul_m8xm8", 2);

        start(4'b0111, 4'b1000);
        follow("mul_7xm8", 4);
        start(4'b1111, 4'b0001);
        follow("mul_m1x1", 4);
        start(4'b0000, 4'b0101);
        follow("mul_0x5", 4);

        // operand change mid-run must be ignored
        start(4'b0111, 4'b0011);
        @(negedge clk);
        @(negedge clk);
        check("ign_n_mid", 8'(n), 8'h02);
        A = 4'b0101;
        B = 4'b1111;
        follow("ign_change", 2);

        // reset mid-run aborts and restarts with the present operands
        start(4'b0111, 4'b0011);
        @(negedge clk);
        @(negedge clk);
        check("abort_n_mid", 8'(n), 8'h02);
        void'(sb.pop_back());
        start(4'b0101, 4'b0011);
        follow("abort_restart", 4);
        hold("abort_restart", 1);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start(4'(a), 4'(b));
                follow("exhaustive", 4);
            end
        end

        check("scoreboard_drained", 8'(sb.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
